rdest_scoreboard: RTL and testbench

Parametrised successor to the register-file write-enable decoder. It accepts destination-register writes at issue and carries them through a fixed-latency writeback pipeline. At writeback it drives the one-hot register-file enable vector. A per-register busy scoreboard stalls issue on read-after-write and write-after-write hazards. It sits between decode/issue and the register file.

---
 rtl/rdest_pkg.sv | 19 +
 rtl/rdest_onehot.sv | 18 +
 rtl/rdest_scoreboard.sv | 118 +++++++++++
 tb/tb_rdest_scoreboard.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/rdest_pkg.sv
// Shared constants, pipeline stage type and one-hot helper for the destination-register scoreboard.
package rdest_pkg;

  localparam int unsigned DEF_NUM_REGS = 16;
  localparam int unsigned DEF_WB_LAT   = 2;
  localparam int unsigned MAX_REGS     = 64;
  localparam int unsigned MAX_IDX_W    = 6;

  typedef struct packed {
    logic                 valid;
    logic [MAX_IDX_W-1:0] idx;
  } stage_t;

  // Widest one-hot; callers truncate to their register count.
  function automatic logic [MAX_REGS-1:0] onehot(input logic [MAX_IDX_W-1:0] idx);
    return MAX_REGS'(1) << idx;
  endfunction

endpackage

// File: rtl/rdest_onehot.sv
// Enabled IDX_W-to-NUM_REGS one-hot decoder; output is all-zero when disabled.
module rdest_onehot
  import rdest_pkg::*;
#(
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                en,
  input  logic [IDX_W-1:0]    idx,
  output logic [NUM_REGS-1:0] onehot_c
);

  always_comb begin
    onehot_c = '0;
    if (en) onehot_c = NUM_REGS'(onehot(MAX_IDX_W'(idx)));
  end

endmodule

// File: rtl/rdest_scoreboard.sv
// Destination-register busy scoreboard with a fixed-latency writeback pipeline and one-hot
// register-file enable. Define RDEST_ZERO_REG_EN to make register 0 a hardwired zero.
module rdest_scoreboard
  import rdest_pkg::*;
#(
  parameter  int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter  int unsigned IDX_W    = $clog2(NUM_REGS),
  parameter  int unsigned WB_LAT   = DEF_WB_LAT,
  localparam int unsigned INF_W    = $clog2(WB_LAT + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                iss_valid,
  input  logic                iss_wen,
  input  logic [IDX_W-1:0]    iss_rdest,
  input  logic [IDX_W-1:0]    iss_rsrc_a,
  input  logic [IDX_W-1:0]    iss_rsrc_b,
  input  logic                iss_use_a,
  input  logic                iss_use_b,
  output logic                iss_ready,
  input  logic                flush,
  output logic [NUM_REGS-1:0] reg_en,
  output logic                wb_valid,
  output logic [IDX_W-1:0]    wb_idx,
  output logic [NUM_REGS-1:0] busy,
  output logic [INF_W-1:0]    inflight
);

  stage_t              st_q [WB_LAT];
  stage_t              st_d [WB_LAT];
  stage_t              new_stage;
  logic                haz_a, haz_b, haz_d;
  logic                accept_wr;
  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] busy_d;
  logic [NUM_REGS-1:0] dec_c;
  logic [NUM_REGS-1:0] reg_en_d;
  logic [INF_W-1:0]    infl_d;

  // Hazard detection looks only at registered busy, never at the writeback enable.
  always_comb begin
    haz_a = iss_use_a & busy[iss_rsrc_a];
    haz_b = iss_use_b & busy[iss_rsrc_b];
    haz_d = iss_wen & busy[iss_rdest];
`ifdef RDEST_ZERO_REG_EN
    haz_a = haz_a & (iss_rsrc_a != '0);
    haz_b = haz_b & (iss_rsrc_b != '0);
`endif
  end

  assign iss_ready = ~flush & ~(haz_a | haz_b | haz_d);

`ifdef RDEST_ZERO_REG_EN
  assign accept_wr = iss_valid & iss_ready & iss_wen & (iss_rdest != '0);
`else
  assign accept_wr = iss_valid & iss_ready & iss_wen;
`endif

  always_comb begin
    new_stage       = '0;
    new_stage.valid = accept_wr;
    if (accept_wr) new_stage.idx = MAX_IDX_W'(iss_rdest);
  end

  // Pipeline advance; flush empties every stage including the one feeding writeback.
  always_comb begin
    st_d[0] = new_stage;
    for (int i = 1; i < int'(WB_LAT); i++) st_d[i] = st_q[i-1];
    if (flush) begin
      for (int i = 0; i < int'(WB_LAT); i++) st_d[i] = '0;
    end
    infl_d = '0;
    for (int i = 0; i < int'(WB_LAT); i++) infl_d = infl_d + INF_W'(st_d[i].valid);
  end

  rdest_onehot #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_dec (
    .en       (st_d[WB_LAT-1].valid),
    .idx      (IDX_W'(st_d[WB_LAT-1].idx)),
    .onehot_c (dec_c)
  );

`ifdef RDEST_ZERO_REG_EN
  localparam logic [NUM_REGS-1:0] ZERO_MASK = ~NUM_REGS'(1);
  assign reg_en_d = dec_c & ZERO_MASK;
`else
  assign reg_en_d = dec_c;
`endif

  // Writeback clear and issue set land on the same edge; they never target the same register.
  always_comb begin
    set_vec = '0;
    if (accept_wr) set_vec = NUM_REGS'(onehot(MAX_IDX_W'(iss_rdest)));
    busy_d = (busy & ~reg_en) | set_vec;
    if (flush) busy_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(WB_LAT); i++) st_q[i] <= '0;
      busy     <= '0;
      reg_en   <= '0;
      inflight <= '0;
    end else begin
      for (int i = 0; i < int'(WB_LAT); i++) st_q[i] <= st_d[i];
      busy     <= busy_d;
      reg_en   <= reg_en_d;
      inflight <= infl_d;
    end
  end

  // Last stage is the writeback cycle; invalid stages carry a zero index.
  assign wb_valid = st_q[WB_LAT-1].valid;
  assign wb_idx   = IDX_W'(st_q[WB_LAT-1].idx);

endmodule

// File: tb/tb_rdest_scoreboard.sv
// Directed table-driven bench for rdest_scoreboard (NUM_REGS=16, WB_LAT=2).
module tb_rdest_scoreboard;

`ifdef RDEST_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        iss_valid, iss_wen, iss_use_a, iss_use_b, flush;
  logic [3:0]  iss_rdest, iss_rsrc_a, iss_rsrc_b;
  logic        iss_ready;
  logic [15:0] reg_en, busy;
  logic        wb_valid;
  logic [3:0]  wb_idx;
  logic [1:0]  inflight;

  int checks = 0;
  int errors = 0;

  rdest_scoreboard #(.NUM_REGS(16), .IDX_W(4), .WB_LAT(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .iss_valid  (iss_valid),
    .iss_wen    (iss_wen),
    .iss_rdest  (iss_rdest),
    .iss_rsrc_a (iss_rsrc_a),
    .iss_rsrc_b (iss_rsrc_b),
    .iss_use_a  (iss_use_a),
    .iss_use_b  (iss_use_b),
    .iss_ready  (iss_ready),
    .flush      (flush),
    .reg_en     (reg_en),
    .wb_valid   (wb_valid),
    .wb_idx     (wb_idx),
    .busy       (busy),
    .inflight   (inflight)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v, w;
    logic [3:0]  rd, ra, rb;
    logic        ua, ub, fl;
    logic        rdy;
    logic [15:0] ren, bsy;
    logic [1:0]  inf;
    logic [3:0]  wbi;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic v, logic w, logic [3:0] rd, logic [3:0] ra, logic [3:0] rb,
                              logic ua, logic ub, logic fl, logic rdy, logic [15:0] ren,
                              logic [15:0] bsy, logic [1:0] inf, logic [3:0] wbi);
    vec_t t;
    t.v = v; t.w = w; t.rd = rd; t.ra = ra; t.rb = rb; t.ua = ua; t.ub = ub; t.fl = fl;
    t.rdy = rdy; t.ren = ren; t.bsy = bsy; t.inf = inf; t.wbi = wbi;
    return t;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic idle_inputs();
    iss_valid = 0; iss_wen = 0; iss_rdest = 0; iss_rsrc_a = 0; iss_rsrc_b = 0;
    iss_use_a = 0; iss_use_b = 0; flush = 0;
  endtask

  task automatic check_all(input string tag, input int idx, input logic rdy, input logic [15:0] ren,
                           input logic [15:0] bsy, input logic [1:0] inf, input logic [3:0] wbi);
    chk({tag, " iss_ready"}, idx, 16'(iss_ready), 16'(rdy));
    chk({tag, " reg_en"},    idx, reg_en, ren);
    chk({tag, " wb_valid"},  idx, 16'(wb_valid), 16'(ren != 16'h0));
    chk({tag, " wb_idx"},    idx, 16'(wb_idx), 16'(wbi));
    chk({tag, " busy"},      idx, busy, bsy);
    chk({tag, " inflight"},  idx, 16'(inflight), 16'(inf));
  endtask

  logic [15:0] z_vec;
  logic [1:0]  z_inf;

  initial begin
    z_vec = ZR ? 16'h0000 : 16'h0001;
    z_inf = ZR ? 2'd0 : 2'd1;
    //            v  w  rd ra rb ua ub fl  rdy ren      bsy      inf wbi
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0)); // reset state
    vecs.push_back(mk(1, 1, 5, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0)); // write r5
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0020, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0020, 16'h0020, 1, 5));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0));
    vecs.push_back(mk(1, 1, 3, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0)); // RAW on r3
    vecs.push_back(mk(1, 0, 0, 3, 0, 1, 0, 0, 0, 16'h0000, 16'h0008, 1, 0));
    vecs.push_back(mk(1, 0, 0, 3, 0, 1, 0, 0, 0, 16'h0008, 16'h0008, 1, 3));
    vecs.push_back(mk(1, 0, 0, 3, 0, 1, 0, 0, 1, 16'h0000, 16'h0000, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0)); // back-to-back
    vecs.push_back(mk(1, 1, 2, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0002, 1, 0));
    vecs.push_back(mk(1, 1, 3, 0, 0, 0, 0, 0, 1, 16'h0002, 16'h0006, 2, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0004, 16'h000C, 2, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0008, 16'h0008, 1, 3));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0));
    vecs.push_back(mk(1, 1, 9, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0)); // WAW on r9
    vecs.push_back(mk(1, 1, 9, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0200, 1, 0));
    vecs.push_back(mk(1, 1, 9, 0, 0, 0, 0, 0, 0, 16'h0200, 16'h0200, 1, 9));
    vecs.push_back(mk(1, 1, 9, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0200, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0200, 16'h0200, 1, 9));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0));
    vecs.push_back(mk(1, 1, 7, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0)); // flush r7, block r8
    vecs.push_back(mk(1, 1, 8, 0, 0, 0, 0, 1, 0, 16'h0000, 16'h0080, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0));
    vecs.push_back(mk(1, 1, 4, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0)); // flush in wb cycle
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0010, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 16'h0010, 16'h0010, 1, 4));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0));
    vecs.push_back(mk(1, 1, 6, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0)); // use flags, wen=0 rdest
    vecs.push_back(mk(1, 0, 6, 6, 6, 0, 0, 0, 1, 16'h0000, 16'h0040, 1, 0));
    vecs.push_back(mk(1, 0, 6, 0, 6, 0, 1, 0, 0, 16'h0040, 16'h0040, 1, 6));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0)); // register 0
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, !ZR ? 1'b0 : 1'b1, 16'h0000, z_vec, z_inf, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, z_vec, z_vec, z_inf, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0));

    idle_inputs();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    foreach (vecs[i]) begin
      iss_valid = vecs[i].v;  iss_wen = vecs[i].w;  iss_rdest = vecs[i].rd;
      iss_rsrc_a = vecs[i].ra; iss_rsrc_b = vecs[i].rb;
      iss_use_a = vecs[i].ua; iss_use_b = vecs[i].ub; flush = vecs[i].fl;
      @(negedge clk);
      check_all("vec", i, vecs[i].rdy, vecs[i].ren, vecs[i].bsy, vecs[i].inf, vecs[i].wbi);
      @(posedge clk);
      #1;
    end

    // Asynchronous reset mid-operation discards an in-flight write.
    idle_inputs();
    iss_valid = 1; iss_wen = 1; iss_rdest = 4'd2;
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check_all("pre_rst", 0, 1'b1, 16'h0000, 16'h0004, 2'd1, 4'd0);
    #1 reset = 1'b1;
    #1 check_all("in_rst", 0, 1'b1, 16'h0000, 16'h0000, 2'd0, 4'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check_all("post_rst", 0, 1'b1, 16'h0000, 16'h0000, 2'd0, 4'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check_all("post_rst", 1, 1'b1, 16'h0000, 16'h0000, 2'd0, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
